// File: rtl/store_buffer.sv
// Posted-write store buffer between the M stage and a req/ack data memory port.
// Optional build macro STORE_COALESCE_EN: stores to an already-buffered address update that entry in place.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       m_we,
    input  logic                       m_re,
    input  logic [AW-1:0]              m_addr,
    input  logic [DW-1:0]              m_wdata,
    output logic [DW-1:0]              m_rdata,
    output logic                       stall,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic [DW-1:0]              mem_rdata,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    // state | meaning
    // IDLE  | no transfer; a load miss is chosen ahead of draining the head
    // DRAIN | writing the head entry to memory, pop on ack
    // LOAD  | reading the missed load address from memory
    // LDONE | captured read data is presented to the pipeline for one cycle

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, LDONE} state_t;

    state_t        state;
    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [DW-1:0] ld_data;

    logic          match;
    logic [PW-1:0] match_idx;
    logic          is_load;
    logic          full;
    logic          pop;
    logic          coalesce;
    logic          enq;
    logic          load_hit;
    logic          load_miss;

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        match     = 1'b0;
        match_idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (ent_addr[head + PW'(i)] == m_addr)) begin
                match     = 1'b1;
                match_idx = head + PW'(i);
            end
        end
    end

    assign is_load = m_re & ~m_we;
    assign full    = (count == CW'(DEPTH));
    assign pop     = (state == DRAIN) & mem_ack;

`ifdef STORE_COALESCE_EN
    // The head under DRAIN is already on the bus, so a store to it must append instead.
    assign coalesce = m_we & match & ~((state == DRAIN) & (match_idx == head));
`else
    assign coalesce = 1'b0;
`endif

    assign enq       = m_we & ~coalesce & ~full;
    assign load_hit  = is_load & match;
    assign load_miss = is_load & ~match;

    always_comb begin
        stall = 1'b0;
        if (m_we) begin
            stall = full & ~coalesce;
        end else if (load_miss) begin
            stall = (state != LDONE);
        end
    end

    assign m_rdata   = load_hit ? ent_data[match_idx] : ld_data;
    assign occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent_addr[tail] <= m_addr;
                ent_data[tail] <= m_wdata;
                tail           <= tail + PW'(1);
            end
            if (coalesce) begin
                ent_data[match_idx] <= m_wdata;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_miss) begin
                        state    <= LOAD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= m_addr;
                    end else if (count != '0) begin
                        state    <= DRAIN;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= ent_addr[head];
                        // A store merging into the head on this same edge must reach the bus.
                        mem_wdata <= (coalesce && (match_idx == head)) ? m_wdata : ent_data[head];
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (mem_ack) begin
                        state   <= LDONE;
                        mem_req <= 1'b0;
                        ld_data <= mem_rdata;
                    end
                end
                LDONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: memory transfers and delivered load data are checked by a monitor.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_we = 1'b0;
    logic          m_re = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata;
    logic          stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [2:0]    occupancy;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           exp_ops [$];
    logic [DW-1:0] exp_ld [$];
    op_t           mon_op;
    logic [DW-1:0] mon_ld;

    int checks = 0;
    int failures = 0;
    int ack_lat = 1;
    bit ack_block = 1'b0;
    int wait_cnt = 0;
    int n_stall;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_we      (m_we),
        .m_re      (m_re),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_value(input logic [AW-1:0] a);
        if (a == 10'h0FF) return 32'hCAFEF00D;
        return 32'h5A5A0000 | 32'(a);
    endfunction

    // Memory: acks ack_lat cycles after the request is first seen, unless blocked.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (rst_n && mem_req && !ack_block) begin
                if (wait_cnt >= ack_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_value(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack) begin
                checks++;
                if (exp_ops.size() == 0) begin
                    failures++;
                    $display("FAIL mem_op unexpected: we=%0d addr=0x%0h data=0x%0h", mem_we, mem_addr, mem_wdata);
                end else begin
                    mon_op = exp_ops.pop_front();
                    if (mem_we !== mon_op.we || mem_addr !== mon_op.addr ||
                        (mon_op.we && mem_wdata !== mon_op.data)) begin
                        failures++;
                        $display("FAIL mem_op: got we=%0d addr=0x%0h data=0x%0h expected we=%0d addr=0x%0h data=0x%0h",
                                 mem_we, mem_addr, mem_wdata, mon_op.we, mon_op.addr, mon_op.data);
                    end
                end
            end
            if (m_re && !m_we && !stall) begin
                checks++;
                if (exp_ld.size() == 0) begin
                    failures++;
                    $display("FAIL load_data unexpected delivery: addr=0x%0h data=0x%0h", m_addr, m_rdata);
                end else begin
                    mon_ld = exp_ld.pop_front();
                    if (m_rdata !== mon_ld) begin
                        failures++;
                        $display("FAIL load_data addr=0x%0h: got 0x%0h expected 0x%0h", m_addr, m_rdata, mon_ld);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.we   = we;
        o.addr = a;
        o.data = d;
        exp_ops.push_back(o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        m_we    = 1'b1;
        m_addr  = a;
        m_wdata = d;
        @(negedge clk);
        while (stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL store_timeout addr=0x%0h: still stalled after %0d cycles", a, n);
        end
        step();
        m_we = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, output int stalls);
        stalls = 0;
        m_re   = 1'b1;
        m_addr = a;
        @(negedge clk);
        while (stall && stalls < 60) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL load_timeout addr=0x%0h: still stalled after %0d cycles", a, stalls);
        end
        step();
        m_re = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((occupancy != 0 || mem_req) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (occupancy != 0 || mem_req) begin
            checks++;
            failures++;
            $display("FAIL %s drain_timeout: occupancy=%0d mem_req=%0d", name, occupancy, mem_req);
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        @(negedge clk);
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_m_rdata", m_rdata, 0);
        chk("rst_stall", 32'(stall), 0);
        step();
        rst_n = 1'b1;

        // Single store, drain with 1-cycle ack latency
        ack_lat = 1;
        push_op(1'b1, 10'h010, 32'hDEADBEEF);
        step();
        m_we    = 1'b1;
        m_addr  = 10'h010;
        m_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_stall", 32'(stall), 0);
        step();
        m_we = 1'b0;
        @(negedge clk);
        chk("t1_occ_after_store", 32'(occupancy), 1);
        chk("t1_no_req_yet", 32'(mem_req), 0);
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_we", 32'(mem_we), 1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h010);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t1_occ_after_ack", 32'(occupancy), 0);
        step();

        // Full buffer stalls; a same-cycle ack does not admit the store
        ack_block = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_op(1'b1, 10'(i), 32'h100 + 32'(i));
            store(10'(i), 32'h100 + 32'(i));
        end
        push_op(1'b1, 10'h005, 32'h105);
        m_we    = 1'b1;
        m_addr  = 10'h005;
        m_wdata = 32'h105;
        @(negedge clk);
        chk("t2_full_stall", 32'(stall), 1);
        chk("t2_full_occ", 32'(occupancy), 4);
        step();
        ack_block = 1'b0;
        ack_lat   = 0;
        @(negedge clk);
        chk("t2_ack_cycle_stall", 32'(stall), 1);
        step();
        ack_block = 1'b1;
        @(negedge clk);
        chk("t2_after_pop_stall", 32'(stall), 0);
        chk("t2_after_pop_occ", 32'(occupancy), 3);
        step();
        m_we = 1'b0;
        @(negedge clk);
        chk("t2_accepted_occ", 32'(occupancy), 4);
        ack_block = 1'b0;
        ack_lat   = 1;
        wait_drain("t2");

        // Youngest-match forwarding with two stores to one address
        ack_block = 1'b1;
`ifdef STORE_COALESCE_EN
        push_op(1'b1, 10'h020, 32'h22222222);
`else
        push_op(1'b1, 10'h020, 32'h11111111);
        push_op(1'b1, 10'h020, 32'h22222222);
`endif
        store(10'h020, 32'h11111111);
        store(10'h020, 32'h22222222);
        exp_ld.push_back(32'h22222222);
        m_re   = 1'b1;
        m_addr = 10'h020;
        @(negedge clk);
        chk("t3_fwd_stall", 32'(stall), 0);
`ifdef STORE_COALESCE_EN
        chk("t3_occ", 32'(occupancy), 1);
`else
        chk("t3_occ", 32'(occupancy), 2);
`endif
        step();
        m_re      = 1'b0;
        ack_block = 1'b0;
        wait_drain("t3");

        // Load miss on empty buffer, memory acks 3 cycles after request
        ack_lat = 3;
        push_op(1'b0, 10'h0FF, 32'h0);
        exp_ld.push_back(32'hCAFEF00D);
        load(10'h0FF, n_stall);
        chk("t4_stall_cycles", 32'(n_stall), 5);
        @(negedge clk);
        chk("t4_idle_after_ldone", 32'(mem_req), 0);
        chk("t4_no_stall_after", 32'(stall), 0);
        step();

        // Load miss raised during DRAIN is served before remaining stores
        ack_block = 1'b1;
        ack_lat   = 1;
        push_op(1'b1, 10'h001, 32'h000000A1);
        push_op(1'b0, 10'h0AA, 32'h0);
        push_op(1'b1, 10'h002, 32'h000000A2);
        push_op(1'b1, 10'h003, 32'h000000A3);
        store(10'h001, 32'h000000A1);
        store(10'h002, 32'h000000A2);
        store(10'h003, 32'h000000A3);
        exp_ld.push_back(32'h5A5A00AA);
        fork
            load(10'h0AA, n_stall);
            begin
                repeat (3) step();
                ack_block = 1'b0;
            end
        join
        wait_drain("t5");

        // Reset in the middle of a drain discards everything
        ack_block = 1'b1;
        store(10'h030, 32'h30);
        store(10'h031, 32'h31);
        store(10'h032, 32'h32);
        @(negedge clk);
        chk("t6_occ_before", 32'(occupancy), 3);
        chk("t6_req_before", 32'(mem_req), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req_in_reset", 32'(mem_req), 0);
        chk("t6_occ_in_reset", 32'(occupancy), 0);
        step();
        rst_n     = 1'b1;
        ack_block = 1'b0;
        ack_lat   = 0;
        repeat (6) step();
        @(negedge clk);
        chk("t6_req_after", 32'(mem_req), 0);
        chk("t6_occ_after", 32'(occupancy), 0);

        chk("exp_ops_left", 32'(exp_ops.size()), 0);
        chk("exp_ld_left", 32'(exp_ld.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's M stage and the data memory port.
- Stores from M retire in one cycle into a FIFO, and the FIFO drains to memory over a req/ack handshake.
- Loads are forwarded from the youngest matching buffered store, or else fetched from memory with a pipeline stall.
- Decouples pipeline timing from a multi-cycle data memory while keeping single-master load/store ordering.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2).
- AW, 10, word-address width (byte address bits [AW+1:2] from ALUOut).
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_we  in  1  M-stage store request (MemWrite).
- m_re  in  1  M-stage load request (MemRead).
- m_addr  in  AW  word address.
- m_wdata  in  DW  store data.
- m_rdata  out  DW  load data, valid when m_re=1 and stall=0.
- stall  out  1  freeze IF..M this cycle (combinational).
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1=write, 0=read; valid with mem_req.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse for the current mem_req.
- occupancy  out  $clog2(DEPTH+1)  buffered entry count.

Behaviour:
- Reset (async): FIFO pointers and count = 0, entries cleared, FSM = IDLE, load data register = 0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, occupancy=0, m_rdata=0.
  - Reset mid-transfer drops mem_req immediately and discards buffered stores.
- FIFO entry = {addr, data}. Stores are full-word only. Head = oldest entry.
- Store enqueue:
  - When m_we=1 and count<DEPTH, the entry is written at the clock edge; stall=0.
  - When m_we=1 and count==DEPTH, stall=1 and nothing is written.
  - A same-cycle drain ack does NOT admit the store; stall clears the cycle after count drops.
- m_we and m_re both high is illegal; it is handled as a store only.
- Load forwarding: on m_re=1, all valid entries are compared with m_addr.
  - On any match, m_rdata = data of the youngest matching entry, combinationally, with stall=0.
  - An entry currently being drained still counts as valid until popped.
- Load miss: stall=1 until the data is delivered.
- FSM states:
  - IDLE: mem_req=0. A load miss goes to LOAD. Otherwise, count>0 goes to DRAIN. Load miss has priority over drain.
  - DRAIN: mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry.
    - On mem_ack: pop head, go to IDLE.
    - The address and data are stable until ack, even if new stores enqueue.
  - LOAD: mem_req=1, mem_we=0, mem_addr = load address captured on entry.
    - On mem_ack: capture mem_rdata, go to LDONE.
  - LDONE: m_rdata = captured data, stall=0 for exactly one cycle, then go to IDLE.
- A load miss raised during DRAIN stalls. After the ack the FSM passes through IDLE, where it selects LOAD before any further drain.
- There is always at least one IDLE cycle between memory transfers.
- The pipeline holds m_re/m_addr stable while stalled. Its own miss is delivered in LDONE.
- Pointers wrap modulo DEPTH. occupancy is updated on the enqueue/pop edge; a simultaneous enqueue and pop leaves it unchanged.

Optional Feature:
- STORE_COALESCE_EN defined:
  - A store whose address matches a valid entry overwrites the youngest such entry's data in place and does not increase count.
  - This applies even when the buffer is full (no stall).
  - Exception: the matching entry is the head while in DRAIN. In that case the store is appended normally.
- STORE_COALESCE_EN undefined: every store appends, and forwarding selects the youngest match.

Test Plan:
- Reset, then store addr 0x010 data 0xDEADBEEF → stall=0; occupancy=1 next cycle; mem_req=1, mem_we=1, mem_addr=0x010 two cycles after the store; ack with 1-cycle latency → occupancy=0.
- Hold mem_ack=0; store addrs 0x001..0x004 → 5th store to 0x005 sees stall=1. Pulse mem_ack → stall=0 the following cycle and the store is accepted.
- Stores 0x020←0x11111111 then 0x020←0x22222222 with ack held off; load 0x020 → m_rdata=0x22222222, stall=0 same cycle. With STORE_COALESCE_EN, occupancy=1.
- Load 0x0FF, buffer empty, memory acks 3 cycles after mem_req with 0xCAFEF00D → stall high until LDONE; m_rdata=0xCAFEF00D with stall=0 for one cycle.
- Load miss to 0x0AA during DRAIN of 0x001 → DRAIN completes first; the next request is a read of 0x0AA before the remaining stores drain.
- rst_n low mid-DRAIN with occupancy=3 → mem_req=0 and occupancy=0 immediately; no write completes after release.
